// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues sequential word reads on a pipelined memory port,
// assembles IWORDS-word instructions (word 0 in the MSBs) and buffers them for decode.
module fetch_queue #(
   parameter int                 WORD_W   = 10,
   parameter int                 ADDR_W   = 14,
   parameter int                 IWORDS   = 3,
   parameter int                 DEPTH    = 4,
   parameter int                 OP_W     = 5,
   parameter logic [ADDR_W-1:0]  RESET_PC = 14'h2000,
   parameter logic [OP_W-1:0]    HALT_OP  = 5'b10011
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic                        redirect,
   input  logic [ADDR_W-1:0]           redirect_pc,
   output logic                        m_read,
   output logic [ADDR_W-1:0]           m_addr,
   input  logic                        m_rvalid,
   input  logic [WORD_W-1:0]           m_rdata,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [IWORDS*WORD_W-1:0]    instr,
   output logic [ADDR_W-1:0]           instr_pc,
   output logic                        halted,
   output logic [$clog2(DEPTH+1)-1:0]  q_count
);

   localparam int INSTR_W = IWORDS * WORD_W;
   localparam int IDX_W   = (IWORDS > 1) ? $clog2(IWORDS) : 1;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IWORDS - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
   logic [IDX_W-1:0]   issue_idx_q, issue_idx_d;
   logic [IDX_W-1:0]   ret_idx_q, ret_idx_d;
   logic [WORD_W-1:0]  asm_q [IWORDS];
   logic [WORD_W-1:0]  asm_d [IWORDS];
   logic [ADDR_W-1:0]  base_pc_q, base_pc_d;
   logic [INSTR_W-1:0] q_instr_q [DEPTH];
   logic [INSTR_W-1:0] q_instr_d [DEPTH];
   logic [ADDR_W-1:0]  q_pc_q [DEPTH];
   logic [ADDR_W-1:0]  q_pc_d [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   open_q, open_d;
   logic               drop_q, drop_d;
   logic               halted_q, halted_d;

   logic               redir;
   logic               room;
   logic               issue;
   logic               ret_ok;
   logic               push;
   logic               deq;
   logic [INSTR_W-1:0] push_instr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
      return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
   endfunction

   assign m_read      = issue;
   assign m_addr      = fetch_addr_q;
   assign instr_valid = (count_q != '0) && !halted_q;
   assign instr       = q_instr_q[rd_ptr_q];
   assign instr_pc    = q_pc_q[rd_ptr_q];
   assign halted      = halted_q;
   assign q_count     = count_q;

   // Open instructions reserve their queue slot at the first issued word, so a push never overflows.
   always_comb begin
      redir  = redirect && !halted_q;
      room   = ({1'b0, count_q} + {1'b0, open_q}) < DEPTH_C;
      issue  = rst && !halted_q && !stall && !redirect && ((issue_idx_q != '0) || room);
      ret_ok = m_rvalid && !drop_q;
      push   = ret_ok && (ret_idx_q == LAST_IDX);
      deq    = instr_valid && instr_ready && !stall && !redir;
   end

   always_comb begin
      push_instr = '0;
      for (int i = 0; i < IWORDS; i++) begin
         push_instr[INSTR_W-1-i*WORD_W -: WORD_W] = (i == IWORDS - 1) ? m_rdata : asm_q[i];
      end
   end

   always_comb begin
      fetch_addr_d = fetch_addr_q;
      issue_idx_d  = issue_idx_q;
      ret_idx_d    = ret_idx_q;
      asm_d        = asm_q;
      base_pc_d    = base_pc_q;
      q_instr_d    = q_instr_q;
      q_pc_d       = q_pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      open_d       = open_q;
      drop_d       = 1'b0;
      halted_d     = halted_q;

      if (issue) begin
         fetch_addr_d = fetch_addr_q + ADDR_W'(1);
         issue_idx_d  = idx_inc(issue_idx_q);
         if (issue_idx_q == '0) begin
            base_pc_d = fetch_addr_q;
            open_d    = open_d + CNT_W'(1);
         end
      end

      if (ret_ok) begin
         asm_d[ret_idx_q] = m_rdata;
         ret_idx_d        = idx_inc(ret_idx_q);
      end

      // With one-cycle read latency base_pc_q still holds this instruction's pc when its last word lands.
      if (push) begin
         q_instr_d[wr_ptr_q] = push_instr;
         q_pc_d[wr_ptr_q]    = base_pc_q;
         wr_ptr_d            = ptr_inc(wr_ptr_q);
         count_d             = count_d + CNT_W'(1);
         open_d              = open_d - CNT_W'(1);
      end

      if (deq) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d  = count_d - CNT_W'(1);
         if (instr[INSTR_W-1 -: OP_W] == HALT_OP) begin
            halted_d = 1'b1;
         end
      end

      if (redir) begin
         fetch_addr_d = redirect_pc;
         issue_idx_d  = '0;
         ret_idx_d    = '0;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
         open_d       = '0;
         drop_d       = 1'b1;
         for (int i = 0; i < IWORDS; i++) begin
            asm_d[i] = '0;
         end
      end
   end

   // drop_q comes out of reset set so a stray return in the first cycle after release is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_addr_q <= RESET_PC;
         issue_idx_q  <= '0;
         ret_idx_q    <= '0;
         base_pc_q    <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         open_q       <= '0;
         drop_q       <= 1'b1;
         halted_q     <= 1'b0;
         for (int i = 0; i < IWORDS; i++) begin
            asm_q[i] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            q_instr_q[i] <= '0;
            q_pc_q[i]    <= '0;
         end
      end else begin
         fetch_addr_q <= fetch_addr_d;
         issue_idx_q  <= issue_idx_d;
         ret_idx_q    <= ret_idx_d;
         base_pc_q    <= base_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         open_q       <= open_d;
         drop_q       <= drop_d;
         halted_q     <= halted_d;
         asm_q        <= asm_d;
         q_instr_q    <= q_instr_d;
         q_pc_q       <= q_pc_d;
      end
   end

endmodule
